locked_seq_multiplier: RTL and testbench
========================================

Name: locked_seq_multiplier

Overview:
- Parametrised, iterative radix-2 shift-add multiplier with XOR key locking on the product.
- Successor to the fixed 8x8 combinational locked multiplier. Adds width/key-width parameters, per-transaction signed/unsigned mode, and valid/ready handshakes on input and output.
- Sits between operand producers and result consumers in the locked datapath. With the correct key the product is exact; with a wrong key it is deterministically corrupted.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits.
- KEY_WIDTH, 64, lock key width; must be >= 2*WIDTH.
- KEY_REF, 64'h192F7F0351667DEC, correct unlock key.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  operands and mode are presented.
- in_ready_o  output  1  block can accept operands.
- operand1_i  input  WIDTH  multiplicand.
- operand2_i  input  WIDTH  multiplier.
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
- keyinput  input  KEY_WIDTH  lock key.
- out_valid_o  output  1  result_o is valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  2*WIDTH  product, corrupted when the key is wrong.

Behaviour:
- Reset (asynchronous, any time, including mid-multiply):
  - FSM goes to IDLE.
  - in_ready_o=1, out_valid_o=0, result_o=0.
  - Accumulator, counter and latched operands/key are cleared.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On a rising edge with in_valid_i=1, latch operands, signed_i and keyinput, then go to BUSY with counter=0.
  - Sign handling on latch: when signed_i=1, each operand is converted to its magnitude and the product sign is recorded as the XOR of the operand MSBs.
  - The most-negative value (e.g. 0x80) has magnitude 2^(WIDTH-1) and is representable in WIDTH unsigned bits.
- BUSY:
  - in_ready_o=0.
  - One multiplier bit per cycle, LSB first: if the bit is 1, add the shifted multiplicand to the 2*WIDTH-bit accumulator.
  - After exactly WIDTH cycles, go to DONE.
  - Latency from acceptance edge to out_valid_o=1 is WIDTH+1 edges; fixed, no early termination on zero operands.
- DONE:
  - out_valid_o=1, in_ready_o=0.
  - result_o = P XOR C, where P is the accumulator, negated in two's complement (mod 2^(2*WIDTH)) if the recorded sign is 1.
  - result_o is stable while out_valid_o=1 and out_ready_i=0 (backpressure; hold indefinitely).
  - On an edge with out_ready_i=1, go to IDLE; out_valid_o drops next cycle.
  - No bypass: a new operand set is accepted no earlier than the edge after returning to IDLE.
- Key and corruption:
  - The key is sampled only at acceptance; changes to keyinput during BUSY/DONE have no effect on the in-flight result.
  - Mask M = latched key XOR KEY_REF.
  - Corruption vector C[i] = XOR of all M[j] with j mod (2*WIDTH) == i, for i in 0..2*WIDTH-1.
  - Correct key gives C=0. Flipping any single key bit flips exactly one result bit.
- in_valid_i while not IDLE is ignored; the producer must hold it until the handshake completes.
- Outputs are registered; result_o is 0 outside DONE.

Test Plan:
- Correct key 64'h192F7F0351667DEC, unsigned:
  - 0x29*0x7A -> result_o=0x138A, out_valid_o high 9 edges after acceptance.
  - 0x89*0xFF -> 0x8877.
  - 0x00*0x01 -> 0x0000.
- Wrong keys, 0x29*0x7A unsigned:
  - key ...7DE8 -> 0x138E.
  - key ...7DE0 -> 0x1386.
  - key 64'h392F7F0351667DEC (bit 61 flipped) -> 0x338A.
- Signed mode, correct key:
  - 0xFF*0x02 -> 0xFFFE (0x01FE with signed_i=0).
  - 0x80*0x80 -> 0x4000.
  - 0x80*0x01 -> 0xFF80.
- Backpressure: hold out_ready_i=0 for 20 cycles -> out_valid_o stays 1 and result_o stays constant. Drive in_valid_i=1 with new operands during DONE -> in_ready_o=0 and they are not accepted. Assert out_ready_i -> new operands accepted one edge after IDLE.
- Reset mid-multiply: assert rst_i at BUSY cycle 3 -> outputs 0/ready immediately (asynchronous). After release, 0x11*0x11 -> 0x0121 with no residue from the aborted operation.
- Key change during BUSY: accept with correct key, switch keyinput to 64'hF92F7F0351667DEC mid-operation -> result still exact. The next transaction is corrupted by C=0xE000 (top byte XOR 0xE0 flips key bits 61-63 -> result bits 13-15).

Source files
------------

// File: rtl/locked_seq_multiplier_if.sv
// Operand/result handshake bundle for the locked sequential multiplier.
interface locked_seq_multiplier_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned KEY_WIDTH = 64
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH-1:0]       operand1_i;
  logic [WIDTH-1:0]       operand2_i;
  logic                   signed_i;
  logic [KEY_WIDTH-1:0]   keyinput;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [2*WIDTH-1:0]     result_o;

  // Producer/consumer side
  modport master (
    output in_valid_i, operand1_i, operand2_i, signed_i, keyinput, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  // Multiplier side
  modport slave (
    input  in_valid_i, operand1_i, operand2_i, signed_i, keyinput, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/locked_seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with XOR key locking on the product.
// Signed operands are multiplied as magnitudes; the sign is applied at the end.
module locked_seq_multiplier #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           KEY_WIDTH = 64,
  parameter logic [KEY_WIDTH-1:0]  KEY_REF   = 64'h192F7F0351667DEC
) (
  input logic                    clk_i,
  input logic                    rst_i,
  locked_seq_multiplier_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [PW-1:0]        result_q, result_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [KEY_WIDTH-1:0] mask;
  logic [PW-1:0]        corr;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [PW-1:0]        prod;

  assign mask = key_q ^ KEY_REF;
  assign mag1 = (bus.signed_i && bus.operand1_i[WIDTH-1]) ? ('0 - bus.operand1_i) : bus.operand1_i;
  assign mag2 = (bus.signed_i && bus.operand2_i[WIDTH-1]) ? ('0 - bus.operand2_i) : bus.operand2_i;
  assign prod = neg_q ? ('0 - acc_q) : acc_q;

  // Fold the key mask modulo the product width into the corruption vector
  always_comb begin
    corr = '0;
    for (int unsigned j = 0; j < KEY_WIDTH; j++) begin
      corr[j % PW] = corr[j % PW] ^ mask[j];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    key_d    = key_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = bus.signed_i & (bus.operand1_i[WIDTH-1] ^ bus.operand2_i[WIDTH-1]);
          key_d    = bus.keyinput;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // WIDTH shift-add steps, then one step applying sign and lock into the output register
        if (cnt_q == CW'(WIDTH)) begin
          result_d = prod ^ corr;
          state_d  = DONE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          result_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      key_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      key_q       <= key_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_locked_seq_multiplier.sv
// Randomized and directed checks of locked_seq_multiplier against an arithmetic model.
module tb_locked_seq_multiplier;

  localparam int unsigned W    = 8;
  localparam int unsigned KW   = 64;
  localparam logic [63:0] KREF = 64'h192F7F0351667DEC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  locked_seq_multiplier_if #(.WIDTH(W), .KEY_WIDTH(KW)) bus ();

  locked_seq_multiplier #(.WIDTH(W), .KEY_WIDTH(KW), .KEY_REF(KREF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Arithmetic product of the operands, XORed with the key mask folded in 16-bit chunks
  function automatic logic [15:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic s, input logic [63:0] key);
    int          pa, pb;
    logic [31:0] p;
    logic [63:0] m;
    logic [15:0] c;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    p  = 32'(pa * pb);
    m  = key ^ KREF;
    c  = '0;
    for (int k = 0; k < int'(KW / (2 * W)); k++) c = c ^ m[k*16 +: 16];
    return p[15:0] ^ c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready, present operands for exactly the acceptance edge
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [63:0] key, input logic [63:0] key_busy);
    int guard = 0;
    while (!bus.in_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    check_eq({tag, "/in_ready"}, 64'(bus.in_ready_o), 64'd1);
    bus.in_valid_i = 1'b1;
    bus.operand1_i = a;
    bus.operand2_i = b;
    bus.signed_i   = s;
    bus.keyinput   = key;
    tick();
    bus.in_valid_i = 1'b0;
    bus.operand1_i = 8'($urandom);
    bus.operand2_i = 8'($urandom);
    bus.signed_i   = 1'($urandom);
    bus.keyinput   = key_busy;
    check_eq({tag, "/busy_ready"}, 64'(bus.in_ready_o), 64'd0);
  endtask

  // Count edges from acceptance until out_valid, bounded
  task automatic wait_out(input string tag);
    int lat = 0;
    while (!bus.out_valid_o && lat < 50) begin
      tick();
      lat++;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'(W + 1));
  endtask

  task automatic drain(input string tag);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check_eq({tag, "/valid_drop"}, 64'(bus.out_valid_o), 64'd0);
    check_eq({tag, "/result_idle"}, 64'(bus.result_o), 64'd0);
    check_eq({tag, "/ready_back"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [63:0] key, input logic [63:0] key_busy,
                         input logic [15:0] exp, input int hold);
    send(tag, a, b, s, key, key_busy);
    wait_out(tag);
    check_eq({tag, "/result"}, 64'(bus.result_o), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "/hold_valid"}, 64'(bus.out_valid_o), 64'd1);
      check_eq({tag, "/hold_result"}, 64'(bus.result_o), 64'(exp));
    end
    drain(tag);
  endtask

  initial begin
    logic [63:0] k, kb;
    logic [7:0]  a, b;
    logic        s;
    bus.in_valid_i  = 1'b0;
    bus.operand1_i  = '0;
    bus.operand2_i  = '0;
    bus.signed_i    = 1'b0;
    bus.keyinput    = '0;
    bus.out_ready_i = 1'b0;

    repeat (3) tick();
    check_eq("reset/in_ready", 64'(bus.in_ready_o), 64'd1);
    check_eq("reset/out_valid", 64'(bus.out_valid_o), 64'd0);
    check_eq("reset/result", 64'(bus.result_o), 64'd0);
    rst = 1'b0;
    tick();

    // Correct key, unsigned
    run_txn("u_29x7a", 8'h29, 8'h7A, 1'b0, KREF, KREF, 16'h138A, 0);
    run_txn("u_89xff", 8'h89, 8'hFF, 1'b0, KREF, KREF, 16'h8877, 0);
    run_txn("u_00x01", 8'h00, 8'h01, 1'b0, KREF, KREF, 16'h0000, 0);
    // Wrong keys
    run_txn("k_7de8", 8'h29, 8'h7A, 1'b0, 64'h192F7F0351667DE8, KREF, 16'h138E, 0);
    run_txn("k_7de0", 8'h29, 8'h7A, 1'b0, 64'h192F7F0351667DE0, KREF, 16'h1386, 0);
    run_txn("k_b61",  8'h29, 8'h7A, 1'b0, 64'h392F7F0351667DEC, KREF, 16'h338A, 0);
    // Signed mode
    run_txn("s_ffx02", 8'hFF, 8'h02, 1'b1, KREF, KREF, 16'hFFFE, 0);
    run_txn("u_ffx02", 8'hFF, 8'h02, 1'b0, KREF, KREF, 16'h01FE, 0);
    run_txn("s_80x80", 8'h80, 8'h80, 1'b1, KREF, KREF, 16'h4000, 0);
    run_txn("s_80x01", 8'h80, 8'h01, 1'b1, KREF, KREF, 16'hFF80, 0);

    // Backpressure with competing operands offered during DONE
    send("bp", 8'h29, 8'h7A, 1'b0, KREF, KREF);
    wait_out("bp");
    bus.in_valid_i = 1'b1;
    bus.operand1_i = 8'h03;
    bus.operand2_i = 8'h05;
    bus.signed_i   = 1'b0;
    bus.keyinput   = KREF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("bp/valid", 64'(bus.out_valid_o), 64'd1);
      check_eq("bp/result", 64'(bus.result_o), 64'h138A);
      check_eq("bp/not_ready", 64'(bus.in_ready_o), 64'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check_eq("bp/valid_drop", 64'(bus.out_valid_o), 64'd0);
    check_eq("bp/ready_idle", 64'(bus.in_ready_o), 64'd1);
    tick();
    bus.in_valid_i = 1'b0;
    check_eq("bp/accepted", 64'(bus.in_ready_o), 64'd0);
    wait_out("bp2");
    check_eq("bp2/result", 64'(bus.result_o), 64'h000F);
    drain("bp2");

    // Asynchronous reset in the middle of a multiply
    send("rst", 8'hFF, 8'hFF, 1'b0, KREF, KREF);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rst/in_ready", 64'(bus.in_ready_o), 64'd1);
    check_eq("rst/out_valid", 64'(bus.out_valid_o), 64'd0);
    check_eq("rst/result", 64'(bus.result_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_txn("rst_11x11", 8'h11, 8'h11, 1'b0, KREF, KREF, 16'h0121, 0);

    // Key only sampled at acceptance
    run_txn("key_mid",  8'h29, 8'h7A, 1'b0, KREF, 64'hF92F7F0351667DEC, 16'h138A, 0);
    run_txn("key_next", 8'h29, 8'h7A, 1'b0, 64'hF92F7F0351667DEC, KREF, 16'hF38A, 0);

    // Randomized transactions against the model
    for (int n = 0; n < 150; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       k = KREF;
        1:       k = KREF ^ (64'd1 << $urandom_range(0, 63));
        default: k = {$urandom, $urandom};
      endcase
      kb = {$urandom, $urandom};
      run_txn("rand", a, b, s, k, kb, ref_model(a, b, s, k), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
